// File: rtl/uart_tx_fifo_if.sv
// Host-to-transmitter word handshake for uart_tx_fifo.
// valid/ready: a word transfers on a rising edge where in_valid && in_ready; in_data is only
// required to be stable in that cycle, and in_valid must not wait on in_ready.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter (5..9 data bits, none/even/odd parity, 1 or 2 stop bits)
// fed by a small FIFO so queued words go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int BPS          = 9_600,
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             sys_clk,
    input  logic                             sys_reset_n,
    uart_tx_fifo_if.slave                    in_if,
    input  logic [1:0]                       parity_mode,
    input  logic                             stop_two,
    output logic                             tx_out,
    output logic                             tx_busy,
    output logic                             tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic [2:0]                       dbg_state
);
    localparam int CPB    = SYS_CLK_FREQ / BPS;
    localparam int CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  CYC_LAST = CNT_W'(CPB - 1);
    localparam logic [3:0]        BIT_LAST = 4'(DATA_W - 1);
    localparam logic [FCNT_W-1:0] FULL     = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic [FCNT_W-1:0] count_d;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // Frame state
    state_t            state_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [3:0]        bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_bit_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              tx_q;
    logic              done_q;
    logic              bit_end;
    logic              stop_final;

    assign in_if.in_ready = (count_q < FULL);
    assign push           = in_if.in_valid && in_if.in_ready;
    assign head           = mem_q[rd_ptr_q];

    assign bit_end    = (cyc_q == CYC_LAST);
    assign stop_final = (state_q == S_STOP) && bit_end && (bit_q[0] || !stop2_q);
    // Pops use the registered count, so a word never falls through in its write cycle.
    assign pop        = (count_q != '0) && ((state_q == S_IDLE) || stop_final);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) cyc_q <= bit_end ? '0 : cyc_q + 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                S_STOP: begin
                    if (stop_final) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end else if (bit_end) begin
                        bit_q <= 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase

            // A pop overrides the case above: both the idle start and the zero-gap chain land here.
            if (pop) begin
                state_q   <= S_START;
                shift_q   <= head;
                par_bit_q <= (^head) ^ (parity_mode == 2'b10);
                par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                stop2_q   <= stop_two;
                tx_q      <= 1'b0;
                cyc_q     <= '0;
                bit_q     <= '0;
            end
        end
    end

    assign tx_out     = tx_q;
    assign tx_done    = done_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, corner-case sequences and randomised
// bursts checked against a bit-list frame model.
module tb_uart_tx_fifo;
    localparam int CPB          = 4;
    localparam int SYS_CLK_FREQ = 40;
    localparam int BPS          = 10;
    localparam int DW           = 8;
    localparam int DEPTH        = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    mode;
        logic          stop2;
    } exp_rec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       stop2;
        int         exp_len;
        int         exp_par;
    } vec_t;

    logic       sys_clk     = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_two    = 1'b0;
    logic       tx_out, tx_busy, tx_done;
    logic [2:0] fifo_count;
    logic [2:0] dbg_state;

    logic [1:0] parity_mode5 = 2'b01;
    logic       stop_two5    = 1'b0;
    logic       tx5_out, tx5_busy, tx5_done;
    logic [1:0] fifo5_count;
    logic [2:0] dbg5_state;

    int       checks   = 0;
    int       errors   = 0;
    int       done_cnt = 0;
    int       b2b_cnt  = 0;
    bit       mon_busy = 1'b0;
    exp_rec_t exp_q[$];

    uart_tx_fifo_if #(.DATA_W(DW)) bus ();
    uart_tx_fifo_if #(.DATA_W(5))  bus5 ();

    uart_tx_fifo #(.DATA_W(DW), .BPS(BPS), .SYS_CLK_FREQ(SYS_CLK_FREQ), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .in_if(bus),
        .parity_mode(parity_mode), .stop_two(stop_two), .tx_out(tx_out), .tx_busy(tx_busy),
        .tx_done(tx_done), .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    uart_tx_fifo #(.DATA_W(5), .BPS(BPS), .SYS_CLK_FREQ(SYS_CLK_FREQ), .FIFO_DEPTH(2)) dut5 (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .in_if(bus5),
        .parity_mode(parity_mode5), .stop_two(stop_two5), .tx_out(tx5_out), .tx_busy(tx5_busy),
        .tx_done(tx5_done), .fifo_count(fifo5_count), .dbg_state(dbg5_state)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected line, one entry per clock: start, data LSB first, optional parity, stop bit(s).
    function automatic void build_frame(input exp_rec_t r, output logic [63:0] v, output int n);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(r.data[i]);
        if (r.mode == 2'b01) bits.push_back(^r.data);
        else if (r.mode == 2'b10) bits.push_back(~^r.data);
        bits.push_back(1'b1);
        if (r.stop2) bits.push_back(1'b1);
        v = '0;
        n = bits.size() * CPB;
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < CPB; c++) v[b*CPB+c] = bits[b];
    endfunction

    task automatic run_frame(output bit aborted, output bit chained);
        exp_rec_t    r;
        logic [63:0] expv;
        logic [63:0] got;
        int          n;
        bit          early;
        aborted  = 1'b0;
        chained  = 1'b0;
        early    = 1'b0;
        got      = '0;
        mon_busy = 1'b1;
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) r = exp_q.pop_front();
        else r = '{data: '0, mode: 2'b00, stop2: 1'b0};
        build_frame(r, expv, n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (!sys_reset_n) begin
                aborted  = 1'b1;
                mon_busy = 1'b0;
                return;
            end
            got[i] = tx_out;
            if (i > 0 && tx_done === 1'b1) early = 1'b1;
        end
        @(negedge sys_clk);
        if (!sys_reset_n) begin
            aborted  = 1'b1;
            mon_busy = 1'b0;
            return;
        end
        check($sformatf("frame_bits_%02h", r.data), got, expv);
        check("tx_done_early", early, 0);
        check("tx_done_at_end", tx_done, 1);
        chained  = (tx_out === 1'b0);
        mon_busy = 1'b0;
    endtask

    initial begin : monitor
        bit ab, ch;
        forever begin
            @(negedge sys_clk);
            if (sys_reset_n && tx_out === 1'b0) begin
                ch = 1'b1;
                while (ch) begin
                    run_frame(ab, ch);
                    if (ab) ch = 1'b0;
                    else if (ch) b2b_cnt++;
                end
            end
        end
    end

    always @(negedge sys_clk) if (sys_reset_n && tx_done === 1'b1) done_cnt++;

    task automatic push(input logic [DW-1:0] d, input logic [1:0] m, input logic s);
        int guard = 0;
        @(negedge sys_clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge sys_clk);
            guard++;
        end
        check("push_timeout", guard < 1000, 1);
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
        exp_q.push_back('{data: d, mode: m, stop2: s});
    endtask

    task automatic wait_idle();
        int guard = 0;
        do begin
            @(negedge sys_clk);
            guard++;
        end while ((tx_busy || fifo_count != 0 || exp_q.size() != 0 || mon_busy) && guard < 3000);
        check("idle_timeout", guard < 3000, 1);
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_cnt < target && guard < 500) begin
            @(negedge sys_clk);
            guard++;
        end
        check("done_timeout", guard < 500, 1);
    endtask

    initial begin : stim
        vec_t        vt[7];
        int          len, d0, b0;
        logic        par_seen, stayed;
        logic [63:0] got5;

        vt[0] = '{8'hA5, 2'b00, 1'b0, 40, -1};
        vt[1] = '{8'h07, 2'b01, 1'b0, 44,  1};
        vt[2] = '{8'h07, 2'b10, 1'b0, 44,  0};
        vt[3] = '{8'h07, 2'b01, 1'b1, 48,  1};
        vt[4] = '{8'hFF, 2'b10, 1'b1, 48,  1};
        vt[5] = '{8'h00, 2'b11, 1'b0, 40, -1};
        vt[6] = '{8'h80, 2'b01, 1'b0, 44,  1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus5.in_valid = 1'b0;
        bus5.in_data  = '0;

        repeat (3) @(negedge sys_clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst5_tx_out", tx5_out, 1);
        sys_reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Vector table: latency, frame length and parity bit value
        for (int t = 0; t < 7; t++) begin
            parity_mode = vt[t].mode;
            stop_two    = vt[t].stop2;
            d0          = done_cnt;
            push(vt[t].data, vt[t].mode, vt[t].stop2);
            @(negedge sys_clk);
            check("lat_high_after_accept", tx_out, 1);
            check("count_after_accept", fifo_count, 1);
            @(negedge sys_clk);
            check("lat_low_next_edge", tx_out, 0);
            check("busy_at_start", tx_busy, 1);
            len      = 0;
            par_seen = 1'bx;
            while (tx_done !== 1'b1 && len < 200) begin
                @(negedge sys_clk);
                len++;
                if (len == 9 * CPB + 1) par_seen = tx_out;
            end
            check($sformatf("frame_len_%0d", t), 64'(len), 64'(vt[t].exp_len));
            if (vt[t].exp_par >= 0) check($sformatf("parity_%0d", t), par_seen, 64'(vt[t].exp_par));
            check("busy_falls_with_done", tx_busy, 0);
            wait_idle();
            check("one_done_pulse", 64'(done_cnt - d0), 1);
        end

        // Burst: one frame in flight, fill FIFO, one more word held off
        parity_mode = 2'b00;
        stop_two    = 1'b0;
        d0 = done_cnt;
        b0 = b2b_cnt;
        for (int i = 0; i < 5; i++) push(DW'($urandom), 2'b00, 1'b0);
        @(negedge sys_clk);
        check("burst_count_full", fifo_count, 4);
        check("burst_in_ready_low", bus.in_ready, 0);
        push(DW'($urandom), 2'b00, 1'b0);
        wait_idle();
        check("burst_done_pulses", 64'(done_cnt - d0), 6);
        check("burst_back_to_back", 64'(b2b_cnt - b0), 5);

        // Config change mid-frame only affects the next popped frame
        d0 = done_cnt;
        push(8'h3C, 2'b00, 1'b0);
        repeat (8) @(negedge sys_clk);
        parity_mode = 2'b01;
        push(8'hC1, 2'b01, 1'b0);
        wait_done(d0 + 1);
        repeat (8) @(negedge sys_clk);
        parity_mode = 2'b00;
        stop_two    = 1'b1;
        wait_idle();
        check("midframe_done_pulses", 64'(done_cnt - d0), 2);
        stop_two = 1'b0;

        // Reset in DATA with three words queued
        push(8'h96, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) push(DW'($urandom), 2'b00, 1'b0);
        @(negedge sys_clk);
        check("rst_test_queued", fifo_count, 3);
        repeat (6) @(negedge sys_clk);
        check("rst_test_in_frame", tx_busy, 1);
        #2;
        sys_reset_n = 1'b0;
        #1;
        check("midrst_tx_out", tx_out, 1);
        check("midrst_fifo_count", fifo_count, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_tx_busy", tx_busy, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        stayed = 1'b1;
        repeat (100) begin
            @(negedge sys_clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) stayed = 1'b0;
        end
        check("no_frame_after_reset", stayed, 1);
        check("no_done_after_reset", 64'(done_cnt - d0), 0);
        push(8'h5A, 2'b00, 1'b0);
        wait_idle();

        // Randomised batches, config held constant within a batch
        for (int b = 0; b < 4; b++) begin
            parity_mode = 2'($urandom_range(0, 3));
            stop_two    = 1'($urandom_range(0, 1));
            d0 = done_cnt;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 20)) @(negedge sys_clk);
                push(DW'($urandom), parity_mode, stop_two);
            end
            wait_idle();
            check($sformatf("rand_done_%0d", b), 64'(done_cnt - d0), 64'(len));
        end

        // 5-bit variant: 0x1F with even parity gives 0 then seven 1 bits
        @(negedge sys_clk);
        bus5.in_valid = 1'b1;
        bus5.in_data  = 5'h1F;
        @(posedge sys_clk);
        #1;
        bus5.in_valid = 1'b0;
        bus5.in_data  = 5'h00;
        @(negedge sys_clk);
        check("dw5_high_after_accept", tx5_out, 1);
        got5 = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge sys_clk);
            got5[i] = tx5_out;
            if (i > 0 && tx5_done === 1'b1) got5[63] = 1'b1;
        end
        check("dw5_frame_bits", got5, 64'h0000_0000_FFFF_FFF0);
        @(negedge sys_clk);
        check("dw5_done_at_32", tx5_done, 1);
        check("dw5_busy_after", tx5_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
